// File: rtl/mbf_pkg.sv
// Shared constants and types for the filter-bank output merger.
// Holds the sample width, default frame length, channel tags and the counter width.
package mbf_pkg;

    localparam int DATA_W    = 8;
    localparam int N_SAMPLES = 527;
    localparam int CNT_W     = 10;

    typedef logic [DATA_W-1:0] sample_t;

    // Channel tags double as the out_ch encoding and the arbitration pointer value.
    typedef enum logic {
        CH_LPF = 1'b0,
        CH_HPF = 1'b1
    } ch_e;

endpackage

// File: rtl/mbf_out_merge_if.sv
// Sample-stream bundle between the filter, the merger and the downstream consumer.
// The master side feeds filter samples and out_ready; the slave side is the merger.
interface mbf_out_merge_if
    import mbf_pkg::*;
();

    sample_t y;
    logic    y_valid;
    sample_t z;
    logic    z_valid;
    sample_t out_data;
    logic    out_ch;
    logic    out_valid;
    logic    out_ready;

    modport master (
        output y, y_valid, z, z_valid, out_ready,
        input  out_data, out_ch, out_valid
    );

    modport slave (
        input  y, y_valid, z, z_valid, out_ready,
        output out_data, out_ch, out_valid
    );

endinterface

// File: rtl/mbf_fifo.sv
// Small synchronous FIFO with registered storage and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module mbf_fifo
    import mbf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  sample_t                din,
    input  logic                   pop,
    output sample_t                dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sample_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage has no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mbf_out_merge.sv
// Merges the LPF and HPF sample streams into one tagged, back-pressured stream.
// Each channel is buffered in its own FIFO and served round-robin into a single output register.
module mbf_out_merge
    import mbf_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int N_SAMPLES = mbf_pkg::N_SAMPLES
) (
    input  logic           clk,
    input  logic           reset,
    mbf_out_merge_if.slave bus,
    output logic           ovf_y,
    output logic           ovf_z,
    output logic           done
);

    localparam int               CW    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(N_SAMPLES);

    sample_t          dout_y;
    sample_t          dout_z;
    logic             full_y;
    logic             full_z;
    logic             empty_y;
    logic             empty_z;
    logic [CW-1:0]    count_y;
    logic [CW-1:0]    count_z;

    logic             live_y;
    logic             live_z;
    logic             push_y;
    logic             push_z;
    logic             pop_y;
    logic             pop_z;
    logic             load;
    logic             xfer;
    ch_e              grant;

    logic [CNT_W-1:0] in_cnt_y;
    logic [CNT_W-1:0] in_cnt_z;
    logic [CNT_W-1:0] out_cnt_y;
    logic [CNT_W-1:0] out_cnt_z;

    logic             out_valid_q;
    sample_t          out_data_q;
    ch_e              out_ch_q;
    ch_e              last_grant;

    logic             valid_nxt;
    sample_t          data_nxt;
    ch_e              ch_nxt;
    ch_e              last_nxt;

    mbf_fifo #(.DEPTH(DEPTH)) u_fifo_y (
        .clk   (clk),
        .reset (reset),
        .push  (push_y),
        .din   (bus.y),
        .pop   (pop_y),
        .dout  (dout_y),
        .full  (full_y),
        .empty (empty_y),
        .count (count_y)
    );

    mbf_fifo #(.DEPTH(DEPTH)) u_fifo_z (
        .clk   (clk),
        .reset (reset),
        .push  (push_z),
        .din   (bus.z),
        .pop   (pop_z),
        .dout  (dout_z),
        .full  (full_z),
        .empty (empty_z),
        .count (count_z)
    );

    // Samples past the frame length are ignored outright, so they never raise an overflow.
    assign live_y = bus.y_valid && (in_cnt_y < LIMIT);
    assign live_z = bus.z_valid && (in_cnt_z < LIMIT);
    assign push_y = live_y && (!full_y || pop_y);
    assign push_z = live_z && (!full_z || pop_z);

    assign load  = (!out_valid_q || bus.out_ready) && (!empty_y || !empty_z);
    assign xfer  = out_valid_q && bus.out_ready;
    assign pop_y = load && (grant == CH_LPF);
    assign pop_z = load && (grant == CH_HPF);

    // With both channels pending the one not served last wins; a lone channel always wins.
    always_comb begin
        grant = CH_LPF;
        if (!empty_y && !empty_z) begin
            grant = (last_grant == CH_HPF) ? CH_LPF : CH_HPF;
        end else if (empty_y) begin
            grant = CH_HPF;
        end
    end

    always_comb begin
        valid_nxt = out_valid_q;
        data_nxt  = out_data_q;
        ch_nxt    = out_ch_q;
        last_nxt  = last_grant;
        if (load) begin
            valid_nxt = 1'b1;
            ch_nxt    = grant;
            last_nxt  = grant;
            data_nxt  = (grant == CH_LPF) ? dout_y : dout_z;
        end else if (bus.out_ready) begin
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= CH_LPF;
            last_grant  <= CH_HPF;
        end else begin
            out_valid_q <= valid_nxt;
            out_data_q  <= data_nxt;
            out_ch_q    <= ch_nxt;
            last_grant  <= last_nxt;
        end
    end

    // Input counts track accepted pushes; output counts track downstream handshakes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_cnt_y  <= '0;
            in_cnt_z  <= '0;
            out_cnt_y <= '0;
            out_cnt_z <= '0;
            ovf_y     <= 1'b0;
            ovf_z     <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (push_y) begin
                in_cnt_y <= in_cnt_y + 1'b1;
            end
            if (push_z) begin
                in_cnt_z <= in_cnt_z + 1'b1;
            end
            if (live_y && !push_y) begin
                ovf_y <= 1'b1;
            end
            if (live_z && !push_z) begin
                ovf_z <= 1'b1;
            end
            if (xfer && (out_ch_q == CH_LPF)) begin
                out_cnt_y <= out_cnt_y + 1'b1;
            end
            if (xfer && (out_ch_q == CH_HPF)) begin
                out_cnt_z <= out_cnt_z + 1'b1;
            end
            if ((out_cnt_y == LIMIT) && (out_cnt_z == LIMIT)) begin
                done <= 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

    a_count_y_bound: assert property (@(posedge clk) disable iff (!reset) count_y <= CW'(DEPTH));
    a_count_z_bound: assert property (@(posedge clk) disable iff (!reset) count_z <= CW'(DEPTH));

endmodule

// File: tb/tb_mbf_out_merge.sv
// Self-checking bench for mbf_out_merge: directed scenarios plus a randomized full frame
// compared against a queue-based behavioural model of the merger.
module tb_mbf_out_merge;
    import mbf_pkg::*;

    localparam int DEPTH = 4;
    localparam int NS    = 527;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic ovf_y;
    logic ovf_z;
    logic done;

    int errors = 0;
    int checks = 0;

    mbf_out_merge_if bus ();

    mbf_out_merge #(.DEPTH(DEPTH), .N_SAMPLES(NS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .ovf_y (ovf_y),
        .ovf_z (ovf_z),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Behavioural model: per-channel queues and a one-entry output slot.
    logic [7:0] qy [$];
    logic [7:0] qz [$];
    bit         m_valid;
    logic [7:0] m_data;
    bit         m_ch;
    bit         m_last;
    bit         m_ovf_y;
    bit         m_ovf_z;
    bit         m_done;
    int         in_y;
    int         in_z;
    int         oc_y;
    int         oc_z;

    task automatic model_reset();
        qy.delete();
        qz.delete();
        m_valid = 0;
        m_data  = 8'h00;
        m_ch    = 0;
        m_last  = 1;
        m_ovf_y = 0;
        m_ovf_z = 0;
        m_done  = 0;
        in_y = 0;
        in_z = 0;
        oc_y = 0;
        oc_z = 0;
    endtask

    task automatic model_step(input bit yv, input logic [7:0] yd, input bit zv,
                              input logic [7:0] zd, input bit rdy);
        int sy;
        int sz;
        bit got_y;
        bit got_z;
        bit load;
        sy = qy.size();
        sz = qz.size();
        got_y = 0;
        got_z = 0;
        m_done = m_done || (oc_y == NS && oc_z == NS);
        if (m_valid && rdy) begin
            if (m_ch) oc_z++;
            else      oc_y++;
        end
        load = (!m_valid || rdy) && (sy > 0 || sz > 0);
        if (load) begin
            if (sy > 0 && (sz == 0 || m_last)) begin
                m_data = qy.pop_front();
                m_ch   = 0;
                got_y  = 1;
            end else begin
                m_data = qz.pop_front();
                m_ch   = 1;
                got_z  = 1;
            end
            m_last  = m_ch;
            m_valid = 1;
        end else if (rdy) begin
            m_valid = 0;
        end
        if (yv && in_y < NS) begin
            if (sy < DEPTH || got_y) begin
                qy.push_back(yd);
                in_y++;
            end else begin
                m_ovf_y = 1;
            end
        end
        if (zv && in_z < NS) begin
            if (sz < DEPTH || got_z) begin
                qz.push_back(zd);
                in_z++;
            end else begin
                m_ovf_z = 1;
            end
        end
    endtask

    task automatic step(input bit yv, input logic [7:0] yd, input bit zv,
                        input logic [7:0] zd, input bit rdy);
        bus.y_valid   = yv;
        bus.y         = yd;
        bus.z_valid   = zv;
        bus.z         = zd;
        bus.out_ready = rdy;
        @(posedge clk);
        model_step(yv, yd, zv, zd, rdy);
        #1;
        bus.y_valid = 1'b0;
        bus.z_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_ch !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out: valid=%b data=%h ch=%b required 0/00/0",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
        checks++;
        if (ovf_y !== 1'b0 || ovf_z !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: ovf_y=%b ovf_z=%b done=%b required 000", ovf_y, ovf_z, done);
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        step(1, 8'h3A, 0, 8'h00, 1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_no_bypass: valid=%b required 0", bus.out_valid);
        end
        step(0, 8'h00, 0, 8'h00, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3A || bus.out_ch !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_out: valid=%b data=%h ch=%b required 1/3a/0",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
        step(0, 8'h00, 0, 8'h00, 1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drop: valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            step(1, 8'h11, 1, 8'h22, 1);
            step(0, 8'h00, 0, 8'h00, 1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || bus.out_ch !== 1'b0) begin
                errors++;
                $display("[TB] FAIL simul_first_%0d: valid=%b data=%h ch=%b required 1/11/0",
                         r, bus.out_valid, bus.out_data, bus.out_ch);
            end
            step(0, 8'h00, 0, 8'h00, 1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22 || bus.out_ch !== 1'b1) begin
                errors++;
                $display("[TB] FAIL simul_second_%0d: valid=%b data=%h ch=%b required 1/22/1",
                         r, bus.out_valid, bus.out_data, bus.out_ch);
            end
            step(0, 8'h00, 0, 8'h00, 1);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL simul_idle_%0d: valid=%b required 0", r, bus.out_valid);
            end
        end
        // HPF-only then both: LPF was not last, so a lone HPF is followed by LPF.
        step(0, 8'h00, 1, 8'h44, 1);
        step(1, 8'h33, 1, 8'h55, 1);
        checks++;
        if (bus.out_data !== 8'h44 || bus.out_ch !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rr_lone_hpf: data=%h ch=%b required 44/1", bus.out_data, bus.out_ch);
        end
        step(0, 8'h00, 0, 8'h00, 1);
        checks++;
        if (bus.out_data !== 8'h33 || bus.out_ch !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_after_hpf: data=%h ch=%b required 33/0", bus.out_data, bus.out_ch);
        end
        step(0, 8'h00, 0, 8'h00, 1);
        step(0, 8'h00, 0, 8'h00, 1);
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step(1, 8'(k), 0, 8'h00, 0);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01 || ovf_y !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold: valid=%b data=%h ovf_y=%b required 1/01/0",
                     bus.out_valid, bus.out_data, ovf_y);
        end
        step(1, 8'h06, 0, 8'h00, 0);
        checks++;
        if (ovf_y !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_ovf: ovf_y=%b required 1", ovf_y);
        end
        for (int e = 1; e <= 5; e++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(e)) begin
                errors++;
                $display("[TB] FAIL bp_drain_%0d: valid=%b data=%h required 1/%h",
                         e, bus.out_valid, bus.out_data, 8'(e));
            end
            step(0, 8'h00, 0, 8'h00, 1);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || ovf_y !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_end: valid=%b ovf_y=%b required 0/1", bus.out_valid, ovf_y);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step(1, 8'(k), 0, 8'h00, 0);
        end
        step(1, 8'h06, 0, 8'h00, 1);
        checks++;
        if (ovf_y !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fullpop_ovf: ovf_y=%b required 0", ovf_y);
        end
        for (int e = 2; e <= 6; e++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(e)) begin
                errors++;
                $display("[TB] FAIL fullpop_drain_%0d: valid=%b data=%h required 1/%h",
                         e, bus.out_valid, bus.out_data, 8'(e));
            end
            step(0, 8'h00, 0, 8'h00, 1);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fullpop_end: valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        step(1, 8'hA1, 1, 8'hB1, 0);
        step(1, 8'hA2, 1, 8'hB2, 0);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_ch !== 1'b0 ||
            ovf_y !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_async: valid=%b data=%h ch=%b ovf_y=%b done=%b required 0/00/0/0/0",
                     bus.out_valid, bus.out_data, bus.out_ch, ovf_y, done);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1, 8'h5C, 1, 8'hC5, 1);
        step(0, 8'h00, 0, 8'h00, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5C || bus.out_ch !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_first: valid=%b data=%h ch=%b required 1/5c/0",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
        step(0, 8'h00, 0, 8'h00, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC5 || bus.out_ch !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_second: valid=%b data=%h ch=%b required 1/c5/1",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
        step(0, 8'h00, 0, 8'h00, 1);
    endtask

    task automatic test_frame();
        int  sent_y;
        int  sent_z;
        bit  yv;
        bit  zv;
        bit  rdy;
        bit  finished;
        int  bad;
        do_reset();
        sent_y   = 0;
        sent_z   = 0;
        finished = 0;
        bad      = 0;
        for (int cyc = 0; cyc < 4800 && !finished; cyc++) begin
            yv  = (cyc % 8 == 0) && (sent_y <= NS);
            zv  = (cyc % 8 == 4) && (sent_z <= NS);
            rdy = 1'($urandom_range(0, 1));
            if (yv) sent_y++;
            if (zv) sent_z++;
            step(yv, 8'($urandom), zv, 8'($urandom), rdy);
            checks++;
            if (bus.out_valid !== m_valid ||
                (m_valid && (bus.out_data !== m_data || bus.out_ch !== m_ch)) ||
                ovf_y !== m_ovf_y || ovf_z !== m_ovf_z || done !== m_done) begin
                errors++;
                if (bad < 10) begin
                    $display("[TB] FAIL frame_cyc_%0d: got v=%b d=%h ch=%b ovf=%b%b done=%b required v=%b d=%h ch=%b ovf=%b%b done=%b",
                             cyc, bus.out_valid, bus.out_data, bus.out_ch, ovf_y, ovf_z, done,
                             m_valid, m_data, m_ch, m_ovf_y, m_ovf_z, m_done);
                end
                bad++;
            end
            finished = (sent_y > NS) && (sent_z > NS) && m_done && !m_valid;
        end
        checks++;
        if (done !== 1'b1 || ovf_y !== 1'b0 || ovf_z !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_done: done=%b ovf_y=%b ovf_z=%b required 1/0/0 (finished=%b)",
                     done, ovf_y, ovf_z, finished);
        end
        step(1, 8'hAA, 1, 8'hBB, 1);
        step(0, 8'h00, 0, 8'h00, 1);
        checks++;
        if (bus.out_valid !== 1'b0 || done !== 1'b1 || ovf_y !== 1'b0 || ovf_z !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_extra_ignored: valid=%b done=%b ovf_y=%b ovf_z=%b required 0/1/0/0",
                     bus.out_valid, done, ovf_y, ovf_z);
        end
    endtask

    initial begin
        bus.y         = 8'h00;
        bus.y_valid   = 1'b0;
        bus.z         = 8'h00;
        bus.z_valid   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_full_pop();
        test_reset_midstream();
        test_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
